// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, LSB first, with one full-adder cell built
//               from two half-adder stages and a single carry flip-flop.
//               A three-state FSM (IDLE/RUN/DONE) sequences one bit per clk.
//               Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that
//               turns the operation into a - b (two's complement).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_c_load;

  // Full-adder cell as two cascaded half adders
  logic               w_h1_s;
  logic               w_h1_c;
  logic               w_h2_c;
  logic               w_s;
  logic               w_c_nxt;
  logic [WIDTH-1:0]   w_res_nxt;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_last    = (r_state == S_RUN) && (r_cnt == c_LAST);

  assign w_h1_s    = r_a[0] ^ r_b[0];
  assign w_h1_c    = r_a[0] & r_b[0];
  assign w_s       = w_h1_s ^ r_carry;
  assign w_h2_c    = w_h1_s & r_carry;
  assign w_c_nxt   = w_h1_c | w_h2_c;

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB
  assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction: a + ~b + 1, so invert b and force the initial carry high
  assign w_b_load  = sub ? ~b : b;
  assign w_c_load  = sub ? 1'b1 : cin;
`else
  assign w_b_load  = b;
  assign w_c_load  = cin;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs decoded from the current state
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand load, per-bit shifting, and result capture on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_res   <= '0;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_nxt;
      r_carry <= w_c_nxt;
      r_cnt   <= r_cnt + c_CNT_W'(1);
      if (w_last) begin
        sum  <= w_res_nxt;
        cout <= w_c_nxt;
      end
    end
  end

endmodule

`default_nettype wire
